// File: rtl/mcp47feb_i2c_target.sv
// Bus-functional I2C write target for an MCP47FEB dual 12-bit DAC.
// Decodes address / command / MSB / LSB frames and latches channel values.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | bus free, waiting for START
// ADDR     | shifting in 7-bit address + R/W
// ADDR_ACK | address matched, drive / release ACK
// CMD      | shifting in command byte
// CMD_ACK  | command accepted, drive / release ACK
// MSB      | shifting in value[11:8] byte
// MSB_ACK  | drive / release ACK for MSB
// LSB      | shifting in value[7:0] byte
// LSB_ACK  | drive / release ACK for LSB, then next command
// IGNORE   | not for us or rejected, wait for START / STOP
module mcp47feb_i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h60,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic [11:0] dac0_value,
  output logic [11:0] dac1_value,
  output logic        dac0_update,
  output logic        dac1_update,
  output logic        busy,
  output logic        nack_pulse
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] F_LOAD = FW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, MSB, MSB_ACK, LSB, LSB_ACK, IGNORE
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    sync1, sync2, filt, filt_q;
  logic [FW-1:0] fcnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= F_LOAD;
    end else begin
      sync1  <= {sda_i, scl_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= F_LOAD;
        end else if (fcnt[i] == '0) begin
          filt[i] <= sync2[i];
          fcnt[i] <= F_LOAD;
        end else begin
          fcnt[i] <= fcnt[i] - FW'(1);
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = filt[0] & ~filt_q[0];
  assign scl_fall  = ~filt[0] & filt_q[0];
  assign start_det = filt[0] & filt_q[0] & filt_q[1] & ~filt[1];
  assign stop_det  = filt[0] & filt_q[0] & ~filt_q[1] & filt[1];

  state_t     state, ack_next;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, byte_next;
  logic [3:0] msb_q;
  logic       sel_q, ack_done, commit_pend;

  assign byte_next = {shreg[6:0], filt[1]};

  always_comb begin
    ack_next = CMD;
    case (state)
      CMD_ACK: ack_next = MSB;
      MSB_ACK: ack_next = LSB;
      default: ack_next = CMD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'd0;
      msb_q       <= 4'd0;
      sel_q       <= 1'b0;
      ack_done    <= 1'b0;
      commit_pend <= 1'b0;
      sda_o       <= 1'b1;
      busy        <= 1'b0;
      nack_pulse  <= 1'b0;
      dac0_value  <= 12'd0;
      dac1_value  <= 12'd0;
      dac0_update <= 1'b0;
      dac1_update <= 1'b0;
    end else begin
      dac0_update <= 1'b0;
      dac1_update <= 1'b0;
      nack_pulse  <= 1'b0;
      // Both value bytes land in one clock, so a channel never shows a half-written value.
      if (commit_pend) begin
        commit_pend <= 1'b0;
        if (sel_q) begin
          dac1_value  <= {msb_q, shreg};
          dac1_update <= 1'b1;
        end else begin
          dac0_value  <= {msb_q, shreg};
          dac0_update <= 1'b1;
        end
      end
      if (stop_det) begin
        state <= IDLE;
        busy  <= 1'b0;
        sda_o <= 1'b1;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 3'd0;
        ack_done <= 1'b0;
        sda_o    <= 1'b1;
      end else begin
        case (state)
          ADDR, CMD, MSB, LSB: begin
            if (scl_rise) begin
              shreg   <= byte_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_done <= 1'b0;
                case (state)
                  ADDR: begin
                    if (byte_next[7:1] == DEV_ADDR && !byte_next[0]) begin
                      state <= ADDR_ACK;
                      busy  <= 1'b1;
                    end else begin
                      state <= IGNORE;
                    end
                  end
                  CMD: begin
                    if (byte_next[7:4] == 4'd0 && byte_next[2:1] == 2'd0) begin
                      sel_q <= byte_next[3];
                      state <= CMD_ACK;
                    end else begin
                      nack_pulse <= 1'b1;
                      busy       <= 1'b0;
                      state      <= IGNORE;
                    end
                  end
                  MSB: begin
                    msb_q <= byte_next[3:0];
                    state <= MSB_ACK;
                  end
                  default: begin
                    commit_pend <= 1'b1;
                    state       <= LSB_ACK;
                  end
                endcase
              end
            end
          end
          // First SCL fall drives the ACK, the second one releases it.
          ADDR_ACK, CMD_ACK, MSB_ACK, LSB_ACK: begin
            if (scl_fall) begin
              if (!ack_done) begin
                sda_o    <= 1'b0;
                ack_done <= 1'b1;
              end else begin
                sda_o   <= 1'b1;
                bit_cnt <= 3'd0;
                state   <= ack_next;
              end
            end
          end
          IGNORE: begin
            sda_o <= 1'b1;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp47feb_i2c_target.sv
// Directed bench for mcp47feb_i2c_target: an I2C master model on a wired-AND SDA.
module tb_mcp47feb_i2c_target;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  wire         sda_bus;
  logic        sda_o;
  logic [11:0] dac0_value, dac1_value;
  logic        dac0_update, dac1_update, busy, nack_pulse;

  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  mcp47feb_i2c_target #(.DEV_ADDR(7'h60), .FILTER_LEN(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .dac0_value  (dac0_value),
    .dac1_value  (dac1_value),
    .dac0_update (dac0_update),
    .dac1_update (dac1_update),
    .busy        (busy),
    .nack_pulse  (nack_pulse)
  );

  int total = 0;
  int bad = 0;
  int upd0_cnt = 0, upd1_cnt = 0, nack_cnt = 0, busy_cnt = 0;
  int upd_seq[$];

  always @(negedge clk) begin
    if (dac0_update) begin
      upd0_cnt++;
      upd_seq.push_back(0);
    end
    if (dac1_update) begin
      upd1_cnt++;
      upd_seq.push_back(1);
    end
    if (nack_pulse) nack_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; wait_clk(Q);
      scl   = 1'b1; wait_clk(2 * Q);
      scl   = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      if (glitch && i == 2) begin
        wait_clk(3); scl = 1'b1; wait_clk(2); scl = 1'b0; wait_clk(Q - 5);
      end else begin
        wait_clk(Q);
      end
      scl = 1'b1;
      if (glitch && i == 4) begin
        wait_clk(Q); sda_m = ~sda_m; wait_clk(1); sda_m = ~sda_m; wait_clk(Q - 1);
      end else begin
        wait_clk(2 * Q);
      end
      scl = 1'b0; wait_clk(Q);
    end
    sda_m = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    ack   = (sda_bus === 1'b0);
    wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic test_reset();
    wait_clk(4);
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b expected 1", sda_o); end
    total++; if (dac0_value !== 12'h000) begin bad++; $display("FAIL reset_dac0: got %h expected 000", dac0_value); end
    total++; if (dac1_value !== 12'h000) begin bad++; $display("FAIL reset_dac1: got %h expected 000", dac1_value); end
    total++; if ({busy, nack_pulse, dac0_update, dac1_update} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, nack_pulse, dac0_update, dac1_update});
    end
    rst = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_basic_write();
    bit a0, a1, a2, a3;
    logic busy_mid;
    int u0 = upd0_cnt, u1 = upd1_cnt;
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    busy_mid = busy;
    send_byte(8'h08, 1'b0, a1);
    send_byte(8'h0A, 1'b0, a2);
    send_byte(8'hBC, 1'b0, a3);
    i2c_stop();
    wait_clk(Q);
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL basic_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
    total++; if (dac1_value !== 12'hABC) begin bad++; $display("FAIL basic_dac1: got %h expected abc", dac1_value); end
    total++; if (dac0_value !== 12'h000) begin bad++; $display("FAIL basic_dac0: got %h expected 000", dac0_value); end
    total++; if (upd1_cnt - u1 != 1 || upd0_cnt - u0 != 0) begin
      bad++; $display("FAIL basic_updates: got %0d/%0d expected 0/1", upd0_cnt - u0, upd1_cnt - u1);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_wrong_addr();
    bit a0, a1, a2, a3;
    int bb = busy_cnt, u0 = upd0_cnt, u1 = upd1_cnt;
    i2c_start();
    send_byte(8'hC2, 1'b0, a0);
    i2c_stop();
    wait_clk(Q);
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL wrong_addr_ack: got %b expected 0", a0); end
    total++; if (busy_cnt != bb) begin bad++; $display("FAIL wrong_addr_busy: got %0d busy cycles expected 0", busy_cnt - bb); end
    total++; if (upd0_cnt != u0 || upd1_cnt != u1 || dac1_value !== 12'hABC) begin
      bad++; $display("FAIL wrong_addr_values: got dac1=%h upd=%0d expected abc/0", dac1_value, upd0_cnt - u0 + upd1_cnt - u1);
    end
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    send_byte(8'h00, 1'b0, a1);
    send_byte(8'h01, 1'b0, a2);
    send_byte(8'h23, 1'b0, a3);
    i2c_stop();
    wait_clk(Q);
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL after_wrong_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    total++; if (dac0_value !== 12'h123 || upd0_cnt - u0 != 1) begin
      bad++; $display("FAIL after_wrong_dac0: got %h/%0d expected 123/1", dac0_value, upd0_cnt - u0);
    end
  endtask

  task automatic test_bad_cmd();
    bit a0, a1, a2;
    logic busy_after;
    int nb = nack_cnt, u0 = upd0_cnt, u1 = upd1_cnt;
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    send_byte(8'h10, 1'b0, a1);
    busy_after = busy;
    send_byte(8'h0A, 1'b0, a2);
    i2c_stop();
    wait_clk(Q);
    total++; if ({a0, a1, a2} !== 3'b100) begin bad++; $display("FAIL bad_cmd_acks: got %b expected 100", {a0, a1, a2}); end
    total++; if (nack_cnt - nb != 1) begin bad++; $display("FAIL bad_cmd_nack: got %0d expected 1", nack_cnt - nb); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL bad_cmd_busy: got %b expected 0", busy_after); end
    total++; if (upd0_cnt != u0 || upd1_cnt != u1 || dac0_value !== 12'h123 || dac1_value !== 12'hABC) begin
      bad++; $display("FAIL bad_cmd_values: got %h/%h expected 123/abc", dac0_value, dac1_value);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] bytes [7] = '{8'hC0, 8'h00, 8'h0F, 8'hFF, 8'h08, 8'h01, 8'h23};
    logic [6:0] acks;
    int base = upd_seq.size();
    int first, second;
    i2c_start();
    for (int i = 0; i < 7; i++) begin
      bit a;
      send_byte(bytes[i], 1'b0, a);
      acks[6 - i] = a;
    end
    i2c_stop();
    wait_clk(Q);
    first  = (upd_seq.size() > base)     ? upd_seq[base]     : -1;
    second = (upd_seq.size() > base + 1) ? upd_seq[base + 1] : -1;
    total++; if (acks !== 7'h7F) begin bad++; $display("FAIL cont_acks: got %b expected 1111111", acks); end
    total++; if (upd_seq.size() - base != 2 || first != 0 || second != 1) begin
      bad++; $display("FAIL cont_order: got n=%0d %0d,%0d expected n=2 0,1", upd_seq.size() - base, first, second);
    end
    total++; if (dac0_value !== 12'hFFF) begin bad++; $display("FAIL cont_dac0: got %h expected fff", dac0_value); end
    total++; if (dac1_value !== 12'h123) begin bad++; $display("FAIL cont_dac1: got %h expected 123", dac1_value); end
  endtask

  task automatic test_partial();
    bit a0, a1, a2, a3;
    int u0 = upd0_cnt, u1 = upd1_cnt;
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    send_byte(8'h08, 1'b0, a1);
    send_byte(8'h05, 1'b0, a2);
    i2c_stop();
    wait_clk(Q);
    total++; if (dac1_value !== 12'h123 || upd1_cnt != u1 || upd0_cnt != u0) begin
      bad++; $display("FAIL stop_after_msb: got %h/%0d expected 123/0", dac1_value, upd1_cnt - u1);
    end
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    send_byte(8'h00, 1'b0, a1);
    send_byte(8'h07, 1'b0, a2);
    send_bits(8'hAB, 4);
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    send_byte(8'h08, 1'b0, a1);
    send_byte(8'h04, 1'b0, a2);
    send_byte(8'h56, 1'b0, a3);
    i2c_stop();
    wait_clk(Q);
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL restart_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    total++; if (dac1_value !== 12'h456 || upd1_cnt - u1 != 1) begin
      bad++; $display("FAIL restart_dac1: got %h/%0d expected 456/1", dac1_value, upd1_cnt - u1);
    end
    total++; if (dac0_value !== 12'hFFF || upd0_cnt != u0) begin
      bad++; $display("FAIL restart_dac0: got %h/%0d expected fff/0", dac0_value, upd0_cnt - u0);
    end
  endtask

  task automatic test_glitch_and_reset();
    bit a0, a1, a2, a3;
    logic busy_pre;
    int u0 = upd0_cnt, bb = busy_cnt;
    sda_m = 1'b0; wait_clk(1); sda_m = 1'b1; wait_clk(Q);
    scl = 1'b0; wait_clk(2); scl = 1'b1; wait_clk(Q);
    total++; if (busy_cnt != bb) begin bad++; $display("FAIL idle_glitch_busy: got %0d busy cycles expected 0", busy_cnt - bb); end
    i2c_start();
    send_byte(8'hC0, 1'b1, a0);
    send_byte(8'h00, 1'b1, a1);
    send_byte(8'h0A, 1'b1, a2);
    send_byte(8'hBC, 1'b1, a3);
    i2c_stop();
    wait_clk(Q);
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL glitch_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    total++; if (dac0_value !== 12'hABC || upd0_cnt - u0 != 1) begin
      bad++; $display("FAIL glitch_dac0: got %h/%0d expected abc/1", dac0_value, upd0_cnt - u0);
    end
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    send_byte(8'h08, 1'b0, a1);
    send_byte(8'h0F, 1'b0, a2);
    send_bits(8'hFF, 3);
    busy_pre = busy;
    total++; if (busy_pre !== 1'b1) begin bad++; $display("FAIL mid_lsb_busy: got %b expected 1", busy_pre); end
    rst = 1'b1;
    #1;
    total++; if (sda_o !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_async_ctl: got sda=%b busy=%b expected 1/0", sda_o, busy); end
    total++; if (dac0_value !== 12'h000 || dac1_value !== 12'h000) begin
      bad++; $display("FAIL rst_async_values: got %h/%h expected 000/000", dac0_value, dac1_value);
    end
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(10);
    rst = 1'b0;
    wait_clk(10);
    i2c_start();
    send_byte(8'hC0, 1'b0, a0);
    send_byte(8'h00, 1'b0, a1);
    send_byte(8'h01, 1'b0, a2);
    send_byte(8'h23, 1'b0, a3);
    i2c_stop();
    wait_clk(Q);
    total++; if (dac0_value !== 12'h123 || dac1_value !== 12'h000) begin
      bad++; $display("FAIL post_rst_frame: got %h/%h expected 123/000", dac0_value, dac1_value);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_bad_cmd();
    test_continuous();
    test_partial();
    test_glitch_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
